ring_osc_meter: RTL and testbench
=================================

# ring_osc_meter

Measures the frequency of an on-chip NOR-based ring oscillator, the sequential counterpart to the team's gate-delay cells. The block holds the ring stopped through its NOR enable input. On `start` it releases the ring, waits a settle period, then counts synchronized rising edges of the ring output over a fixed window of `clk` cycles. It reports the saturated edge count with a one-cycle `valid` strobe. It sits between the free-running oscillator macro and the tinytapeout user I/O / readout logic.

## Interface
- `WINDOW_CYCLES`, 1024: length of the counting window in `clk` cycles (≥1).
- `SETTLE_CYCLES`, 16: cycles the ring runs before counting starts (≥1).
- `CNT_W`, 16: width of the edge counter and result.
- `clk` in 1: single system clock; all logic is on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: request a measurement; sampled only in IDLE.
- `osc_in` in 1: ring oscillator tap, asynchronous to `clk`; pre-divided externally so its frequency is < f_clk/2.
- `osc_stop` out 1: drives one input of the ring's NOR stage. 1 holds the ring stopped; 0 lets it oscillate.
- `busy` out 1: high from SETTLE through DONE.
- `valid` out 1: one-cycle strobe, asserted when `count` is updated.
- `count` out CNT_W: last measured edge count; holds until the next DONE.

## Operation
- `osc_in` passes through a 2-FF synchronizer, then a registered edge detector (`prev`). A rise means sync=1 and prev=0.
- FSM states:
  - IDLE: `osc_stop`=1, `busy`=0, edge counter cleared, `prev` forced to 1. Forcing `prev` to 1 ensures a ring already high is never counted as an edge. On `start`=1, go to SETTLE.
  - SETTLE: `osc_stop`=0. The cycle counter runs 0..SETTLE_CYCLES-1, then goes to COUNT. Edges are not counted.
  - COUNT: `osc_stop`=0. The cycle counter runs 0..WINDOW_CYCLES-1. Each detected rise increments the edge counter, which saturates at 2^CNT_W−1. At the end of the window, go to DONE.
  - DONE: `osc_stop`=1, `count` ← edge counter, `valid`=1 for exactly this cycle, then go to IDLE.
- The cycle counter is wide enough for max(WINDOW_CYCLES, SETTLE_CYCLES). It is reset to 0 on every state entry.
- `start` is ignored in SETTLE, COUNT and DONE; it is not queued.
- Only edges whose detection falls in a COUNT cycle are counted. Edges in flight in the synchronizer at the end of the window are discarded.
- Reset (`rst_n`=0 at a clock edge), in any state including mid-COUNT: next state is IDLE, `osc_stop`=1, `busy`=0, `valid`=0, `count`=0, counters=0, synchronizer flops=0, `prev`=1.

## Timing
- Reset values: `osc_stop`=1, `busy`=0, `valid`=0, `count`=0.
- `start` is high at edge N (in IDLE). At N+1 the FSM is in SETTLE: `osc_stop`=0 and `busy`=1.
- COUNT occupies cycles N+1+SETTLE_CYCLES through N+SETTLE_CYCLES+WINDOW_CYCLES.
- DONE, with `valid`=1 and the new `count`, is at cycle N+1+SETTLE_CYCLES+WINDOW_CYCLES.
- Latency from `start` to `valid` is 1+SETTLE_CYCLES+WINDOW_CYCLES cycles.
- A `start` held high through DONE begins a new measurement from the following IDLE cycle, so the earliest restart is one cycle after DONE.
- `osc_in` → edge detection latency is 3 clk cycles (two synchronizer stages plus the edge register).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `ring_osc_pkg` holds:
  - the state enum (`S_IDLE`, `S_SETTLE`, `S_COUNT`, `S_DONE`);
  - a `clog2`-based width helper for the cycle counter.
- Sub-module `sync_2ff` (1-bit, `clk`/`rst_n`, reset to 0). It is reused by later blocks that sample asynchronous gate-level outputs.
- The top-level block holds the FSM, the cycle counter, the edge detector and the saturating edge counter.

## Test plan
- WINDOW=16, SETTLE=4; `osc_in` is a square wave with one rise every 4 clk → `valid` one cycle at start+21, `count`=4, then `osc_stop`=1 and `busy`=0.
- `osc_in` stuck at 1 through the whole measurement → `count`=0; no false edge counted at window start.
- CNT_W=3, WINDOW=32; `osc_in` rising every 2 clk (16 rises) → `count`=7 (saturated, no wrap).
- `start` pulsed repeatedly during SETTLE and COUNT → exactly one `valid` and unchanged latency. `start` held high → second `valid` exactly 22 cycles after the first (WINDOW=16, SETTLE=4).
- `rst_n`=0 for one cycle mid-COUNT after a prior result of 4 → next cycle IDLE, `osc_stop`=1, `count`=0, `valid`=0, `busy`=0. A following `start` then yields a normal result.
- Check `osc_stop` over the whole measurement → 0 exactly during SETTLE+COUNT (SETTLE_CYCLES+WINDOW_CYCLES cycles), 1 otherwise.

Source files
------------

// File: rtl/ring_osc_pkg.sv
// rtl/ring_osc_pkg.sv - shared types and helpers for the ring oscillator meter
package ring_osc_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_COUNT  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Bits needed for a counter that runs 0..max(a,b)-1 (never less than one bit).
    function automatic int cyc_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - 1-bit two-flop synchronizer for asynchronous inputs
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops give the first stage a full cycle to resolve.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/ring_osc_meter.sv
// rtl/ring_osc_meter.sv - gated ring oscillator frequency meter (settle, count window, report)
module ring_osc_meter
    import ring_osc_pkg::*;
#(
    parameter int WINDOW_CYCLES = 1024,
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_osc_in,
    output logic             o_osc_stop,
    output logic             o_busy,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_count
);

    localparam int               CYC_W       = cyc_width(WINDOW_CYCLES, SETTLE_CYCLES);
    localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
    localparam logic [CYC_W-1:0] WINDOW_LAST = CYC_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t           r_state;
    state_t           w_next_state;
    logic [CYC_W-1:0] r_cyc;
    logic [CNT_W-1:0] r_edge;
    logic [CNT_W-1:0] w_edge_next;
    logic             r_prev;
    logic             w_sync;
    logic             w_rise;
    logic             r_osc_stop;
    logic             r_busy;
    logic             r_valid;
    logic [CNT_W-1:0] r_count;

    sync_2ff u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_osc_in),
        .o_q     (w_sync)
    );

    assign w_rise = w_sync & ~r_prev;

    // Next-state and next edge-count; edges only count while in COUNT, saturating at all-ones.
    always_comb begin
        w_next_state = r_state;
        w_edge_next  = r_edge;
        case (r_state)
            S_IDLE: begin
                w_edge_next = '0;
                if (i_start) w_next_state = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_cyc == SETTLE_LAST) w_next_state = S_COUNT;
            end
            S_COUNT: begin
                if (w_rise && (r_edge != CNT_MAX)) w_edge_next = r_edge + CNT_W'(1);
                if (r_cyc == WINDOW_LAST) w_next_state = S_DONE;
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register and cycle counter; the counter restarts from zero on every state entry.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cyc   <= '0;
        end else begin
            r_state <= w_next_state;
            if ((w_next_state != r_state) || (r_state == S_IDLE)) r_cyc <= '0;
            else                                                 r_cyc <= r_cyc + CYC_W'(1);
        end
    end

    // Edge path; prev is held high in IDLE so a ring that starts high is not seen as a rise.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_prev <= 1'b1;
            r_edge <= '0;
        end else begin
            r_prev <= (r_state == S_IDLE) ? 1'b1 : w_sync;
            r_edge <= w_edge_next;
        end
    end

    // Outputs registered from the next state so they line up with the state they describe.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_osc_stop <= 1'b1;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_count    <= '0;
        end else begin
            r_osc_stop <= (w_next_state == S_IDLE) || (w_next_state == S_DONE);
            r_busy     <= (w_next_state != S_IDLE);
            r_valid    <= (w_next_state == S_DONE);
            if (w_next_state == S_DONE) r_count <= w_edge_next;
        end
    end

    assign o_osc_stop = r_osc_stop;
    assign o_busy     = r_busy;
    assign o_valid    = r_valid;
    assign o_count    = r_count;

endmodule

// File: tb/tb_ring_osc_meter.sv
// tb/tb_ring_osc_meter.sv - directed self-checking bench for ring_osc_meter
module tb_ring_osc_meter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        start2;
    logic        osc_in;
    logic        osc_stop;
    logic        busy;
    logic        valid;
    logic [15:0] count;
    logic        osc_stop2;
    logic        busy2;
    logic        valid2;
    logic [2:0]  count2;

    int n_checks;
    int n_fail;
    int osc_mode;   // 0 low, 1 high, 2 rise every 4 clk, 3 rise every 2 clk
    int phase;

    ring_osc_meter #(.WINDOW_CYCLES(16), .SETTLE_CYCLES(4), .CNT_W(16)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_osc_in   (osc_in),
        .o_osc_stop (osc_stop),
        .o_busy     (busy),
        .o_valid    (valid),
        .o_count    (count)
    );

    ring_osc_meter #(.WINDOW_CYCLES(32), .SETTLE_CYCLES(4), .CNT_W(3)) dut_sat (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start2),
        .i_osc_in   (osc_in),
        .o_osc_stop (osc_stop2),
        .o_busy     (busy2),
        .o_valid    (valid2),
        .o_count    (count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Oscillator model: phase advances once per clk on the falling edge.
    always @(negedge clk) begin
        phase = phase + 1;
        case (osc_mode)
            1:       osc_in = 1'b1;
            2:       osc_in = phase[1];
            3:       osc_in = phase[0];
            default: osc_in = 1'b0;
        endcase
    end

    // Pulse start for one edge, then wait for valid; returns cycles after the start edge and osc_stop-low cycles.
    task automatic run_meas(output int lat, output int stop_low);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        stop_low = 0;
        while (!valid && lat < 200) begin
            if (!osc_stop) stop_low++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (osc_stop !== 1'b1) begin n_fail++; $display("FAIL reset_osc_stop got=%b exp=1", osc_stop); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid); end
        n_checks++; if (count !== 16'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_checks++; if (osc_stop2 !== 1'b1) begin n_fail++; $display("FAIL reset_osc_stop2 got=%b exp=1", osc_stop2); end
        n_checks++; if (count2 !== 3'd0) begin n_fail++; $display("FAIL reset_count2 got=%0d exp=0", count2); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_square();
        int lat, stop_low;
        osc_mode = 2;
        repeat (4) @(negedge clk);
        n_checks++; if (osc_stop !== 1'b1) begin n_fail++; $display("FAIL idle_osc_stop got=%b exp=1", osc_stop); end
        run_meas(lat, stop_low);
        n_checks++; if (lat != 20) begin n_fail++; $display("FAIL square_latency got=%0d exp=20", lat); end
        n_checks++; if (count !== 16'd4) begin n_fail++; $display("FAIL square_count got=%0d exp=4", count); end
        n_checks++; if (stop_low != 20) begin n_fail++; $display("FAIL square_stop_low_cycles got=%0d exp=20", stop_low); end
        n_checks++; if (osc_stop !== 1'b1) begin n_fail++; $display("FAIL done_osc_stop got=%b exp=1", osc_stop); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL done_busy got=%b exp=1", busy); end
        @(negedge clk);
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL valid_one_cycle got=%b exp=0", valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL after_busy got=%b exp=0", busy); end
        n_checks++; if (osc_stop !== 1'b1) begin n_fail++; $display("FAIL after_osc_stop got=%b exp=1", osc_stop); end
        n_checks++; if (count !== 16'd4) begin n_fail++; $display("FAIL count_hold got=%0d exp=4", count); end
    endtask

    task automatic test_stuck_high();
        int lat, stop_low;
        osc_mode = 1;
        repeat (4) @(negedge clk);
        run_meas(lat, stop_low);
        n_checks++; if (lat != 20) begin n_fail++; $display("FAIL stuck_latency got=%0d exp=20", lat); end
        n_checks++; if (count !== 16'd0) begin n_fail++; $display("FAIL stuck_count got=%0d exp=0", count); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_saturate();
        int lat;
        osc_mode = 3;
        repeat (4) @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        lat = 0;
        while (!valid2 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        n_checks++; if (lat != 36) begin n_fail++; $display("FAIL sat_latency got=%0d exp=36", lat); end
        n_checks++; if (count2 !== 3'd7) begin n_fail++; $display("FAIL sat_count got=%0d exp=7", count2); end
        @(negedge clk);
        n_checks++; if (valid2 !== 1'b0) begin n_fail++; $display("FAIL sat_valid_one_cycle got=%b exp=0", valid2); end
        n_checks++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL sat_busy_after got=%b exp=0", busy2); end
    endtask

    task automatic test_start_pulses();
        int lat, extra;
        osc_mode = 2;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!valid && lat < 200) begin
            start = (lat < 18) ? ((lat % 2) == 0) : 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        n_checks++; if (lat != 20) begin n_fail++; $display("FAIL pulses_latency got=%0d exp=20", lat); end
        n_checks++; if (count !== 16'd4) begin n_fail++; $display("FAIL pulses_count got=%0d exp=4", count); end
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid || busy) extra++;
        end
        n_checks++; if (extra != 0) begin n_fail++; $display("FAIL pulses_queued_restart got=%0d exp=0", extra); end
    endtask

    task automatic test_back_to_back();
        int lat, gap;
        osc_mode = 2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        lat = 0;
        while (!valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        n_checks++; if (lat != 20) begin n_fail++; $display("FAIL b2b_first_latency got=%0d exp=20", lat); end
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!valid && gap < 200);
        start = 1'b0;
        n_checks++; if (gap != 22) begin n_fail++; $display("FAIL b2b_gap got=%0d exp=22", gap); end
        n_checks++; if (count !== 16'd4) begin n_fail++; $display("FAIL b2b_count got=%0d exp=4", count); end
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid_count();
        int lat, stop_low;
        osc_mode = 2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midcount_busy got=%b exp=1", busy); end
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (osc_stop !== 1'b1) begin n_fail++; $display("FAIL rst_mid_osc_stop got=%b exp=1", osc_stop); end
        n_checks++; if (count !== 16'd0) begin n_fail++; $display("FAIL rst_mid_count got=%0d exp=0", count); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got=%b exp=0", valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_meas(lat, stop_low);
        n_checks++; if (lat != 20) begin n_fail++; $display("FAIL post_rst_latency got=%0d exp=20", lat); end
        n_checks++; if (count !== 16'd4) begin n_fail++; $display("FAIL post_rst_count got=%0d exp=4", count); end
        n_checks++; if (stop_low != 20) begin n_fail++; $display("FAIL post_rst_stop_low got=%0d exp=20", stop_low); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        osc_mode = 0;
        phase    = 0;
        osc_in   = 1'b0;
        start    = 1'b0;
        start2   = 1'b0;
        rst_n    = 1'b0;
        test_reset();
        test_square();
        test_stuck_high();
        test_saturate();
        test_start_pulses();
        test_back_to_back();
        test_reset_mid_count();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
